neuron_engine: RTL and testbench
================================

# neuron_engine

Parametrised single-neuron multiply-accumulate engine for the MLP datapath: accepts a bias and a stream of N_INPUTS (input, weight) pairs in sign-magnitude over a valid/ready handshake. Accumulates in a saturating two's-complement accumulator, then scales, applies a selectable activation (ReLU or identity) and saturates to DATA_W. Sits between the layer controller (start, bias, streamed operands) and the next-layer input buffer (out_valid/out_ready).

## Interface
- DATA_W, 8: width of input, weight, bias and output words (sign-magnitude, MSB = sign)
- ACC_W, 21: accumulator width (two's complement)
- N_INPUTS, 4: pairs accumulated per neuron evaluation (≥1)
- SHIFT, 9: right shift applied to accumulator magnitude before activation

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin evaluation; honoured only in IDLE
- bias  in  DATA_W  sign-magnitude bias, sampled with start
- act_mode  in  1  0 = ReLU, 1 = identity; sampled with start
- in_valid  in  1  in_data/in_weight valid
- in_ready  out  1  engine accepts a pair this cycle
- in_data  in  DATA_W  sign-magnitude input
- in_weight  in  DATA_W  sign-magnitude weight
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_W  sign-magnitude result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, ACT, DONE.
- IDLE: in_ready=0. On start: acc ← sign-extended bias magnitude << SHIFT (negated if bias sign set), pair counter ← 0, mode latched; → ACCUM.
- ACCUM: in_ready=1. Transfer when in_valid&&in_ready: pair registered into stage-1 register, stage-1 valid set, counter+1. On the N_INPUTS-th transfer → DRAIN (in_ready low from next cycle).
- Stage 2 (any state): when stage-1 valid, product = (mag_x·mag_w), negated if sign_x XOR sign_w, sign-extended to ACC_W and added to acc; stage-1 valid clears unless refilled the same cycle.
- Accumulator add saturates to +(2^(ACC_W-1)−1) / −(2^(ACC_W-1)−1); no wrap.
- DRAIN: last product accumulated; → ACT.
- ACT: mag = |acc| >> SHIFT (truncation toward zero); ReLU with acc<0 → 0; else magnitude clamped to 2^(DATA_W-1)−1, sign = acc sign. Result registered to out_data; → DONE.
- DONE: out_valid=1, out_data stable until out_valid&&out_ready, then → IDLE. start ignored in DONE.
- Zero result always encoded 0x00 (never negative zero); input negative zero (e.g. 0x80) treated as 0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, acc=0, counter=0, stage-1 valid=0, state IDLE.
- start at edge t → in_ready=1 from cycle t+1.
- One pair per cycle at full throughput; gaps in in_valid stall counter only.
- Last pair accepted at edge k → out_valid=1 after edge k+2. Minimum start-to-out_valid: N_INPUTS+3 cycles.
- out_ready high while out_valid → out_valid low and busy low next cycle; next start accepted from then.
- rst at any cycle (mid-ACCUM, DONE with out_valid) returns all state to reset values next edge; partial acc discarded.
- in_valid outside ACCUM ignored; operands must be held until transfer.

## Structure
- Shared package (mlp_pkg): state enum, sign-magnitude↔two's-complement conversion functions, saturation helper, default DATA_W/ACC_W/SHIFT constants.
- One natural sub-module: sm_mac_stage (sign-magnitude multiply + saturating accumulate, parametrised DATA_W/ACC_W); FSM, counter and activation/saturation in neuron_engine.

## Test plan
- Defaults, bias=0, ReLU, 4×(0x7F,0x7F) → acc=64516, out_data=0x7E (126), out_valid 2 cycles after last transfer.
- Bias=0, ReLU, pairs (0x40,0x40)×3 + (0xA0,0x40) → acc=10240, out_data=0x14; same with identity → 0x14.
- Identity, 4×(0xC0,0x40) → acc=−16384, out_data=0xA0; ReLU same stimulus → 0x00.
- Bias=0x05, 4×(0x00,0x7F) → out_data=0x05; bias=0x7F + 4×(0x7F,0x7F) → 0x7F (output clamp); ACC_W=17 same stimulus → acc clamps to 65535, out 0x7F.
- Random in_valid gaps plus out_ready low 5 cycles → out_data held stable, single transfer, busy drops the cycle after handshake; start during DONE ignored.
- rst asserted after 2 transfers → in_ready=0, busy=0 next cycle; fresh start yields result independent of prior partial sum.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and arithmetic helpers for the MLP datapath.
// Conversion and saturation helpers run at a fixed wide width so modules
// with any DATA_W/ACC_W (up to 62 bits) can use them and then slice.
package mlp_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 21;
  localparam int DEF_SHIFT  = 9;
  localparam int WIDE_W     = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;
  typedef logic        [WIDE_W-2:0] mag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_ACT,
    ST_DONE
  } state_t;

  // Magnitude plus sign flag to two's complement; a zero magnitude is 0 either way.
  function automatic wide_t sm_to_tc(input mag_t mag, input logic neg);
    wide_t v;
    v = wide_t'({1'b0, mag});
    return neg ? -v : v;
  endfunction

  function automatic wide_t abs_tc(input wide_t v);
    return (v < 0) ? -v : v;
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is never produced.
  function automatic wide_t sat_sym(input wide_t v, input int unsigned w);
    wide_t lim;
    lim = (wide_t'(1) <<< (w - 1)) - 1;
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

  // Two's complement to sign-magnitude in the low w bits, magnitude clamped.
  // Zero always comes out with a clear sign bit.
  function automatic wide_t tc_to_sm(input wide_t v, input int unsigned w);
    wide_t mag;
    wide_t lim;
    logic  neg;
    lim = (wide_t'(1) <<< (w - 1)) - 1;
    mag = abs_tc(v);
    if (mag > lim)
      mag = lim;
    neg = (v < 0) && (mag != 0);
    return neg ? (mag | (wide_t'(1) <<< (w - 1))) : mag;
  endfunction

endpackage

// File: rtl/sm_mac_stage.sv
// Two-stage sign-magnitude multiply with saturating two's-complement accumulate.
// Stage 1 captures an accepted operand pair; stage 2 multiplies it and adds
// the signed product into the accumulator. ACC_W must be at least 2*DATA_W-1
// so a single product always fits.
module sm_mac_stage
  import mlp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic                    in_fire,
  input  logic [DATA_W-1:0]       x_sm,
  input  logic [DATA_W-1:0]       w_sm,
  output logic                    vld_p1,
  output logic signed [ACC_W-1:0] acc_p2
);

  localparam int MAG_W = DATA_W - 1;

  logic [MAG_W-1:0] mag_x_p1;
  logic [MAG_W-1:0] mag_w_p1;
  logic             neg_p1;
  mag_t             prod_mag;
  wide_t            sum_w;
  wide_t            sat_w;
  logic             unused_hi;

  // Stage 1 valid: set by an accepted pair, clears unless refilled
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= in_fire;
  end

  // Stage 1 operands: magnitudes and product sign of the accepted pair
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mag_x_p1 <= x_sm[MAG_W-1:0];
      mag_w_p1 <= w_sm[MAG_W-1:0];
      neg_p1   <= x_sm[DATA_W-1] ^ w_sm[DATA_W-1];
    end
  end

  // Stage 2 arithmetic: signed product added to the accumulator, then clamped
  always_comb begin
    prod_mag = mag_t'(mag_x_p1) * mag_t'(mag_w_p1);
    sum_w    = wide_t'(acc_p2) + sm_to_tc(prod_mag, neg_p1);
    sat_w    = sat_sym(sum_w, ACC_W);
  end

  // Upper bits of the clamped sum are a copy of the sign at this width.
  assign unused_hi = ^sat_w[WIDE_W-1:ACC_W];

  // Stage 2 accumulator: bias preload on start, otherwise accumulate products
  always_ff @(posedge clk) begin
    if (rst)
      acc_p2 <= '0;
    else if (load)
      acc_p2 <= load_val;
    else if (vld_p1)
      acc_p2 <= sat_w[ACC_W-1:0];
  end

endmodule

// File: rtl/neuron_engine.sv
// Single-neuron MAC engine: bias preload, streamed sign-magnitude pairs,
// saturating accumulate, scale by SHIFT, ReLU/identity, sign-magnitude output.
module neuron_engine
  import mlp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int N_INPUTS = 4,
  parameter int SHIFT    = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              act_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int              MAG_W    = DATA_W - 1;
  localparam int              CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    relu_q;
  logic                    in_fire;
  logic                    load;
  logic                    last_fire;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic signed [ACC_W-1:0] load_val;
  wide_t                   bias_w;
  wide_t                   acc_w;
  wide_t                   mag_w;
  wide_t                   res_w;
  wide_t                   sm_w;
  logic [DATA_W-1:0]       act_data;
  logic                    unused_hi;

  assign in_fire   = in_valid && in_ready;
  assign load      = start && (state_q == ST_IDLE);
  assign last_fire = in_fire && (cnt_q == LAST_CNT);

  // Bias preload value: magnitude scaled into accumulator units, signed, clamped
  always_comb begin
    bias_w   = sat_sym(sm_to_tc(mag_t'(bias[MAG_W-1:0]) << SHIFT, bias[DATA_W-1]), ACC_W);
    load_val = bias_w[ACC_W-1:0];
  end

  sm_mac_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .in_fire  (in_fire),
    .x_sm     (in_data),
    .w_sm     (in_weight),
    .vld_p1   (vld_p1),
    .acc_p2   (acc_p2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic; DRAIN lets the last stage-1 pair reach the accumulator
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (last_fire) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_ACT;
      ST_ACT:   state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Pair counter and latched activation mode
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      relu_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= '0;
      relu_q <= ~act_mode;
    end else if (in_fire) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Activation: scale magnitude toward zero, ReLU, clamp and re-encode
  always_comb begin
    acc_w = wide_t'(acc_p2);
    mag_w = abs_tc(acc_w) >> SHIFT;
    if (relu_q && (acc_w < 0))
      res_w = '0;
    else
      res_w = sm_to_tc(mag_w[WIDE_W-2:0], acc_w < 0);
    sm_w     = tc_to_sm(res_w, DATA_W);
    act_data = sm_w[DATA_W-1:0];
  end

  // Wide helper results carry more bits than this configuration needs.
  assign unused_hi = ^{bias_w[WIDE_W-1:ACC_W], mag_w[WIDE_W-1], sm_w[WIDE_W-1:DATA_W], vld_p1};

  // Output register: captured in ACT, held through DONE
  always_ff @(posedge clk) begin
    if (rst)
      out_data <= '0;
    else if (state_q == ST_ACT)
      out_data <= act_data;
  end

endmodule

// File: tb/tb_neuron_engine.sv
// Scoreboard bench for neuron_engine: default instance plus an ACC_W=17 instance
// driven by the same stimulus.
module tb_neuron_engine;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bias;
  logic       act_mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_weight;
  logic       out_ready;
  logic       in_ready,   out_valid,   busy;
  logic [7:0] out_data;
  logic       in_ready17, out_valid17, busy17;
  logic [7:0] out_data17;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] d17;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] xs[N];
  logic [7:0] ws[N];

  always #5 clk = ~clk;

  neuron_engine dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  neuron_engine #(.ACC_W(17)) dut17 (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready17), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid17), .out_ready(out_ready), .out_data(out_data17), .busy(busy17)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint sm_val(input logic [7:0] v);
    longint m;
    m = longint'(v[6:0]);
    return v[7] ? -m : m;
  endfunction

  function automatic longint clamp(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Reference result for the pairs currently in xs/ws
  function automatic logic [7:0] model(input logic [7:0] b, input logic ident, input int accw);
    longint lim;
    longint acc;
    longint mag;
    logic [7:0] r;
    lim = (longint'(1) <<< (accw - 1)) - 1;
    acc = clamp(sm_val(b) * 512, lim);
    for (int i = 0; i < N; i++)
      acc = clamp(acc + sm_val(xs[i]) * sm_val(ws[i]), lim);
    mag = ((acc < 0) ? -acc : acc) / 512;
    if (mag > 127) mag = 127;
    if ((!ident && acc < 0) || mag == 0)
      r = 8'h00;
    else
      r = {(acc < 0), mag[6:0]};
    return r;
  endfunction

  task automatic run_txn(input string name, input logic [7:0] b, input logic ident,
                         input logic gaps, input int hold);
    exp_t e;
    int   cyc;
    e.d   = model(b, ident, 21);
    e.d17 = model(b, ident, 17);
    sb.push_back(e);
    bias = b; act_mode = ident; start = 1'b1;
    tick;
    start = 1'b0;
    chk($sformatf("%s.in_ready_start", name), in_ready, 1);
    chk($sformatf("%s.busy_start", name), busy, 1);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data = 8'($urandom); in_weight = 8'($urandom);
        repeat ($urandom_range(0, 2)) tick;
      end
      in_data = xs[i]; in_weight = ws[i]; in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    chk($sformatf("%s.in_ready_drain", name), in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    chk($sformatf("%s.latency", name), cyc, 2);
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s.hold_valid", name), out_valid, 1);
      chk($sformatf("%s.hold_data", name), out_data, sb[0].d);
      if (h == 1) begin
        start = 1'b1; bias = 8'h33;
      end
      tick;
      start = 1'b0;
    end
    e = sb.pop_front();
    chk($sformatf("%s.data", name), out_data, e.d);
    chk($sformatf("%s.valid17", name), out_valid17, 1);
    chk($sformatf("%s.data17", name), out_data17, e.d17);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk($sformatf("%s.valid_after", name), out_valid, 0);
    chk($sformatf("%s.busy_after", name), busy, 0);
    tick;
    chk($sformatf("%s.idle_in_ready", name), in_ready, 0);
    chk($sformatf("%s.idle_valid", name), out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; bias = '0; act_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    tick;
    tick;
    chk("reset.in_ready", in_ready, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_data", out_data, 0);
    chk("reset.busy", busy, 0);
    chk("reset.out_data17", out_data17, 0);
    rst = 1'b0;
    tick;

    xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F}; ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    run_txn("max_relu", 8'h00, 1'b0, 1'b0, 0);

    xs = '{8'h40, 8'h40, 8'h40, 8'hA0}; ws = '{8'h40, 8'h40, 8'h40, 8'h40};
    run_txn("mix_relu", 8'h00, 1'b0, 1'b0, 0);
    run_txn("mix_ident", 8'h00, 1'b1, 1'b0, 0);

    xs = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    run_txn("neg_ident", 8'h00, 1'b1, 1'b0, 0);
    run_txn("neg_relu", 8'h00, 1'b0, 1'b0, 0);

    xs = '{8'h00, 8'h80, 8'h00, 8'h00}; ws = '{8'h7F, 8'h7F, 8'h7F, 8'h80};
    run_txn("bias_only", 8'h05, 1'b0, 1'b0, 0);
    run_txn("neg_bias", 8'h85, 1'b1, 1'b0, 0);

    xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F}; ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    run_txn("out_clamp", 8'h7F, 1'b1, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = 8'($urandom);
        ws[i] = 8'($urandom);
      end
      run_txn($sformatf("rand%0d", r), 8'($urandom), 1'($urandom), 1'b1, 5);
    end

    // Reset in the middle of accumulation
    xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    bias = 8'h7F; act_mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    in_data = 8'h7F; in_weight = 8'h7F; in_valid = 1'b1;
    tick;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("rst_accum.in_ready", in_ready, 0);
    chk("rst_accum.busy", busy, 0);
    chk("rst_accum.out_valid", out_valid, 0);
    rst = 1'b0;
    tick;
    xs = '{8'h10, 8'h10, 8'h90, 8'h10}; ws = '{8'h10, 8'h10, 8'h20, 8'h30};
    run_txn("after_rst", 8'h00, 1'b1, 1'b0, 0);

    // Reset while a result is waiting in DONE
    xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F}; ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    bias = 8'h00; act_mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    in_data = 8'h7F; in_weight = 8'h7F; in_valid = 1'b1;
    repeat (N) tick;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick;
      cyc++;
    end
    chk("rst_done.valid_before", out_valid, 1);
    chk("rst_done.data_before", out_data, 8'h7E);
    rst = 1'b1;
    tick;
    chk("rst_done.out_valid", out_valid, 0);
    chk("rst_done.out_data", out_data, 0);
    chk("rst_done.busy", busy, 0);
    chk("rst_done.out_data17", out_data17, 0);
    rst = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
